// File: rtl/i8080_master.sv
// i8080_master: 8-bit 8080-style LCD bus initiator with programmable CS setup, strobe-low and strobe-high timing.
// Define I8080_CS_KEEP_EN to accept back-to-back requests in the last HOLD cycle without releasing CS.
module i8080_master #(
  parameter int CS_SETUP = 2,
  parameter int LOW_CYC  = 3,
  parameter int HIGH_CYC = 3,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       i8080_CS,
  output logic       i8080_RS,
  output logic       i8080_WR,
  output logic       i8080_RD,
  output logic [7:0] i8080_DO,
  output logic       i8080_DOE,
  input  logic [7:0] i8080_DI
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rd_q;
  logic             last;
  logic             accept;

  assign last = (cnt == '0);

`ifdef I8080_CS_KEEP_EN
  assign cmd_ready = !RST && ((state == IDLE) || ((state == HOLD) && last));
`else
  assign cmd_ready = !RST && (state == IDLE);
`endif

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);

  // Each state loads the down-counter on entry and leaves when it reaches zero.
  // A request accepted in HOLD (keep mode) re-enters SETUP with CS still low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      i8080_CS  <= 1'b1;
      i8080_RS  <= 1'b0;
      i8080_WR  <= 1'b1;
      i8080_RD  <= 1'b1;
      i8080_DO  <= 8'h00;
      i8080_DOE <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        state     <= SETUP;
        cnt       <= SETUP_LD;
        rd_q      <= cmd_rd;
        i8080_CS  <= 1'b0;
        i8080_RS  <= cmd_rs;
        i8080_DO  <= cmd_data;
        i8080_DOE <= !cmd_rd;
      end else begin
        case (state)
          SETUP: begin
            if (last) begin
              state <= STROBE;
              cnt   <= LOW_LD;
              if (rd_q) i8080_RD <= 1'b0;
              else      i8080_WR <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          STROBE: begin
            if (last) begin
              state    <= HOLD;
              cnt      <= HIGH_LD;
              i8080_WR <= 1'b1;
              i8080_RD <= 1'b1;
              if (rd_q) begin
                rsp_data  <= i8080_DI;
                rsp_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HOLD: begin
            if (last) begin
              state     <= IDLE;
              i8080_CS  <= 1'b1;
              i8080_DOE <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i8080_master.sv
// tb_i8080_master: directed and random checks of i8080_master against a cycle-window model and a pin-level bus slave.
// Honours I8080_CS_KEEP_EN when the bench is built with it.
module tb_i8080_master;

  localparam int S = 2;
  localparam int L = 3;
  localparam int H = 3;
`ifdef I8080_CS_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid_f = 1'b0;
  logic       cmd_rd = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;

  logic       m_ready, m_rv, m_busy, m_cs, m_rs, m_wr, m_rdn, m_doe;
  logic [7:0] m_rdat, m_dout;
  logic       f_ready, f_rv, f_busy, f_cs, f_rs, f_wr, f_rdn, f_doe;
  logic [7:0] f_rdat, f_dout;

  logic [7:0] smem [2] = '{8'h00, 8'h00};
  logic [7:0] expmem [2] = '{8'h00, 8'h00};
  logic [7:0] s_di;

  int vectors = 0;
  int miscompares = 0;

  int   k1, k2, acc, gap, kc;
  logic cs_tr [40];
  logic wr_tr [40];
  logic [7:0] do_tr [40];
  logic       r_rd, r_rs;
  logic [7:0] r_data, r_exp;

  always #5 CLK = ~CLK;

  // Pin-level slave: latches the bus during WR low and returns a scrambled register on reads.
  assign s_di = smem[m_rs] ^ 8'h5A;
  always @(posedge CLK) if (!RST && !m_cs && !m_wr) smem[m_rs] <= m_dout;

  i8080_master #(.CS_SETUP(S), .LOW_CYC(L), .HIGH_CYC(H), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(m_ready), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .rsp_valid(m_rv), .rsp_data(m_rdat), .busy(m_busy),
    .i8080_CS(m_cs), .i8080_RS(m_rs), .i8080_WR(m_wr), .i8080_RD(m_rdn), .i8080_DO(m_dout),
    .i8080_DOE(m_doe), .i8080_DI(s_di)
  );

  i8080_master #(.CS_SETUP(1), .LOW_CYC(1), .HIGH_CYC(1), .CNT_W(4)) dut_fast (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid_f), .cmd_ready(f_ready), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .rsp_valid(f_rv), .rsp_data(f_rdat), .busy(f_busy),
    .i8080_CS(f_cs), .i8080_RS(f_rs), .i8080_WR(f_wr), .i8080_RD(f_rdn), .i8080_DO(f_dout),
    .i8080_DOE(f_doe), .i8080_DI(8'h00)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and checks every cycle of it against the CS/strobe windows implied by the timing.
  task automatic applyStimulus(input logic rd, input logic rs, input logic [7:0] data,
                               input bit fast, input logic [7:0] exp_rsp);
    int s, l, h, total;
    logic cs, wr, rdn, doe, rv, rdy, rsv, strobe;
    logic [7:0] dout, rdat;
    s = fast ? 1 : S;
    l = fast ? 1 : L;
    h = fast ? 1 : H;
    total = s + l + h;
    cmd_rd = rd;
    cmd_rs = rs;
    cmd_data = data;
    if (fast) cmd_valid_f = 1'b1;
    else      cmd_valid = 1'b1;
    rdy = fast ? f_ready : m_ready;
    checkOutput("ready_at_issue", rdy, 1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_valid_f = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      cs   = fast ? f_cs    : m_cs;
      wr   = fast ? f_wr    : m_wr;
      rdn  = fast ? f_rdn   : m_rdn;
      doe  = fast ? f_doe   : m_doe;
      rv   = fast ? f_rv    : m_rv;
      rdy  = fast ? f_ready : m_ready;
      rsv  = fast ? f_rs    : m_rs;
      dout = fast ? f_dout  : m_dout;
      rdat = fast ? f_rdat  : m_rdat;
      strobe = (k >= s + 1) && (k <= s + l);
      checkOutput("cs", cs, (k <= total) ? 0 : 1);
      checkOutput("wr", wr, (!rd && strobe) ? 0 : 1);
      checkOutput("rd", rdn, (rd && strobe) ? 0 : 1);
      checkOutput("doe", doe, (k <= total) && !rd);
      checkOutput("wr_rd_overlap", !wr && !rdn, 0);
      checkOutput("strobe_cs_high", cs && (!wr || !rdn), 0);
      checkOutput("rsp_valid", rv, rd && (k == s + l + 1));
      checkOutput("ready", rdy, (k == total + 1) || (KEEP && (k == total)));
      if (k <= total) begin
        checkOutput("rs", rsv, rs);
        if (!rd) checkOutput("dout", dout, data);
      end
      if (rd && (k == s + l + 1)) checkOutput("rsp_data", rdat, exp_rsp);
      if (k <= total) @(negedge CLK);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge CLK);
    checkOutput("rst_cs", m_cs, 1);
    checkOutput("rst_wr", m_wr, 1);
    checkOutput("rst_rd", m_rdn, 1);
    checkOutput("rst_rs", m_rs, 0);
    checkOutput("rst_do", m_dout, 8'h00);
    checkOutput("rst_doe", m_doe, 0);
    checkOutput("rst_rsp_valid", m_rv, 0);
    checkOutput("rst_rsp_data", m_rdat, 8'h00);
    checkOutput("rst_busy", m_busy, 0);
    checkOutput("rst_ready", m_ready, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed write, then a write/read pair through the slave (0x66 ^ 0x5A = 0x3C)
    applyStimulus(1'b0, 1'b0, 8'hA5, 1'b0, 8'h00);
    expmem[0] = 8'hA5;
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 8'h00);
    expmem[1] = 8'h66;
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 8'h3C);

    // Minimum timing: single-cycle strobe, 4-cycle transfer
    applyStimulus(1'b0, 1'b1, 8'h5C, 1'b1, 8'h00);

    // Back-to-back writes with cmd_valid held high
    k1 = -100; k2 = -100; acc = 0;
    cmd_rd = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h11; cmd_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cs_tr[k] = m_cs;
      wr_tr[k] = m_wr;
      do_tr[k] = m_dout;
      if (cmd_valid && m_ready) begin
        if (acc == 0) k1 = k;
        else          k2 = k;
        acc++;
      end else if (acc == 1) cmd_data = 8'h22;
      else if (acc == 2) cmd_valid = 1'b0;
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    expmem[0] = 8'h22;
    checkOutput("b2b_accepts", acc, 2);
    checkOutput("b2b_spacing", k2 - k1, KEEP ? 8 : 9);
    gap = 0;
    for (int k = k1 + 1; k <= k2 + 1; k++) if (k >= 0 && k < 30 && cs_tr[k]) gap++;
    checkOutput("b2b_cs_gap", gap, KEEP ? 0 : 1);
    kc = (k2 >= 0 && k2 < 26) ? k2 : 0;
    checkOutput("b2b_do_before", do_tr[kc], 8'h11);
    checkOutput("b2b_do_setup", do_tr[kc + 1], 8'h22);
    checkOutput("b2b_wr_high", wr_tr[kc + 2], 1);
    checkOutput("b2b_wr_fall", wr_tr[kc + 3], 0);
    for (int i = 0; i < 20 && m_busy; i++) @(negedge CLK);
    checkOutput("b2b_idle", m_busy, 0);

    // Reset asserted during STROBE of a read
    cmd_rd = 1'b1; cmd_rs = 1'b1; cmd_valid = 1'b1;
    checkOutput("abort_ready", m_ready, 1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("abort_in_strobe", m_rdn, 0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_cs", m_cs, 1);
    checkOutput("abort_wr", m_wr, 1);
    checkOutput("abort_rd", m_rdn, 1);
    checkOutput("abort_doe", m_doe, 0);
    checkOutput("abort_rsp_valid", m_rv, 0);
    checkOutput("abort_ready_in_rst", m_ready, 0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort_ready_after", m_ready, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort_no_rsp", m_rv, 0);
      @(negedge CLK);
    end

    // Random mix against the register model
    for (int n = 0; n < 200; n++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_rs = 1'($urandom_range(0, 1));
      r_data = 8'($urandom);
      r_exp = expmem[r_rs] ^ 8'h5A;
      applyStimulus(r_rd, r_rs, r_data, 1'b0, r_exp);
      if (!r_rd) expmem[r_rs] = r_data;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
